// File: rtl/frontend_window.sv
// Age-ordered instruction window between fetch and issue: compacting storage,
// delay-slot tracking and single-step load-use hoisting within a lookahead range.
module frontend_window #(
  parameter int DEPTH     = 4,
  parameter int LOOKAHEAD = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [30:0] in_rmask,
  input  logic [30:0] in_wmask,
  input  logic        in_branch,
  input  logic        in_mem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [2:0]  out_sel,
  output logic [3:0]  count,
  output logic [31:0] swaps
);

  localparam int LA = (LOOKAHEAD < DEPTH) ? LOOKAHEAD : DEPTH;

  // slot marks an entry that was accepted directly after a branch.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [30:0] rmask;
    logic [30:0] wmask;
    logic        branch;
    logic        mem;
    logic        slot;
  } entry_t;

  entry_t      r_win [DEPTH];
  entry_t      w_next [DEPTH];
  entry_t      w_new;
  entry_t      w_out;
  logic [3:0]  r_count;
  logic        r_last_branch;
  logic [31:0] r_swaps;

  logic [LA-1:0] w_elig;
  logic [2:0]    w_sel;
  logic          w_head_blocked;
  logic          w_valid;
  logic          w_room;
  logic          w_accept;
  logic          w_drop;
  logic          w_store;
  logic          w_issue;
  logic [3:0]    w_wr_pos;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and in_ready depends only on occupancy.
  assign w_room   = (r_count < 4'(DEPTH));
  assign w_accept = in_valid & w_room;
  assign w_drop   = (in_instr == 32'd0) & ~r_last_branch;
  assign w_store  = w_accept & ~w_drop;
  assign w_issue  = out_valid & out_ready;
  assign w_wr_pos = r_count - {3'b000, w_issue};

  always_comb begin
    w_elig    = '0;
    w_elig[0] = (r_count != 4'd0);
    for (int j = 1; j < LA; j++) begin
      w_elig[j] = (j < int'(r_count)) && !r_win[j].branch;
      for (int i = 0; i < j; i++) begin
        if (r_win[i].branch) w_elig[j] = 1'b0;
        if (r_win[i].mem && r_win[j].mem) w_elig[j] = 1'b0;
        if (((r_win[j].wmask & (r_win[i].rmask | r_win[i].wmask)) |
             (r_win[i].wmask & (r_win[j].rmask | r_win[j].wmask))) != 31'd0)
          w_elig[j] = 1'b0;
      end
    end
  end

  // Only a memory-op head may be overtaken, and never while it is a delay slot,
  // so a branch and its slot always leave back-to-back.
  always_comb begin
    w_sel = '0;
    if (r_win[0].mem && !r_win[0].slot) begin
      for (int j = LA - 1; j >= 1; j--) begin
        if (w_elig[j] && !r_win[j].mem) w_sel = 3'(j);
      end
    end
  end

  assign w_head_blocked = r_win[0].branch && (r_count == 4'd1);
  assign w_valid        = w_elig[0] && !w_head_blocked;

  always_comb begin
    w_out = r_win[0];
    for (int k = 1; k < LA; k++) begin
      if (3'(k) == w_sel) w_out = r_win[k];
    end
  end

  always_comb begin
    w_new.pc     = in_pc;
    w_new.instr  = in_instr;
    w_new.rmask  = in_rmask;
    w_new.wmask  = in_wmask;
    w_new.branch = in_branch;
    w_new.mem    = in_mem;
    w_new.slot   = r_last_branch;
  end

  // Remove the issued entry by shifting younger ones down, then append.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_next[k] = r_win[k];
      if (w_issue && (3'(k) >= w_sel))
        w_next[k] = r_win[(k == DEPTH - 1) ? k : k + 1];
      if (w_store && (4'(k) == w_wr_pos))
        w_next[k] = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count       <= 4'd0;
      r_last_branch <= 1'b0;
      r_swaps       <= 32'd0;
    end else if (flush) begin
      r_count       <= 4'd0;
      r_last_branch <= 1'b0;
    end else begin
      r_count <= r_count + {3'b000, w_store} - {3'b000, w_issue};
      if (w_accept) r_last_branch <= in_branch;
      if (w_issue && (w_sel != 3'd0)) r_swaps <= r_swaps + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) r_win[k] <= w_next[k];
  end

  assign in_ready  = w_room | ~resetn;
  assign out_valid = w_valid & resetn;
  assign out_pc    = w_out.pc;
  assign out_instr = w_out.instr;
  assign out_sel   = w_sel;
  assign count     = r_count;
  assign swaps     = r_swaps;

endmodule

// File: tb/tb_frontend_window.sv
// Directed bench for frontend_window: per-cycle vector table on a DEPTH=4,
// LOOKAHEAD=2 window, plus hand sequences (in-order instance, reset mid-stream).
module tb_frontend_window;

  localparam int K_NONE = 0, K_ADD = 1, K_SUB = 2, K_LW = 3, K_ADDU = 4,
                 K_DEP = 5, K_BEQ = 6, K_NOP = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, flush, in_valid, in_branch, in_mem, out_ready;
  logic [31:0] in_pc, in_instr;
  logic [30:0] in_rmask, in_wmask;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr, swaps;
  logic [2:0]  out_sel;
  logic [3:0]  count;
  logic        in_ready1, out_valid1;
  logic [31:0] out_pc1, out_instr1, swaps1;
  logic [2:0]  out_sel1;
  logic [3:0]  count1;

  frontend_window #(.DEPTH(4), .LOOKAHEAD(2)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rmask(in_rmask), .in_wmask(in_wmask),
    .in_branch(in_branch), .in_mem(in_mem), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_sel(out_sel), .count(count), .swaps(swaps)
  );

  frontend_window #(.DEPTH(4), .LOOKAHEAD(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_instr(in_instr), .in_rmask(in_rmask), .in_wmask(in_wmask),
    .in_branch(in_branch), .in_mem(in_mem), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .out_instr(out_instr1), .out_sel(out_sel1), .count(count1),
    .swaps(swaps1)
  );

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_sel;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
    logic [31:0] e_sw;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // add $1,$2,$3 / sub $4,$1,$5 / lw $8,0($9) / addu $10,$11,$12 / addu $10,$8,$12 / beq $1,$2
  task automatic drive_kind(input int kind, input logic [31:0] pc, input logic fl,
                            input logic ordy);
    in_valid  = (kind != K_NONE);
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    in_branch = 1'b0;
    in_mem    = 1'b0;
    in_rmask  = '0;
    in_wmask  = '0;
    in_instr  = 32'd0;
    case (kind)
      K_ADD:  begin in_instr = 32'h00430820; in_rmask = 31'h6;   in_wmask = 31'h1;   end
      K_SUB:  begin in_instr = 32'h00252022; in_rmask = 31'h11;  in_wmask = 31'h8;   end
      K_LW:   begin in_instr = 32'h8D280000; in_rmask = 31'h100; in_wmask = 31'h80;
                    in_mem = 1'b1; end
      K_ADDU: begin in_instr = 32'h016C5021; in_rmask = 31'hC00; in_wmask = 31'h200; end
      K_DEP:  begin in_instr = 32'h010C5021; in_rmask = 31'h880; in_wmask = 31'h200; end
      K_BEQ:  begin in_instr = 32'h10220004; in_rmask = 31'h3;   in_branch = 1'b1;   end
      default: in_instr = 32'd0;
    endcase
  endtask

  task automatic row(input int kind, input logic [31:0] pc, input logic fl, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [2:0] e_sel,
                     input logic [31:0] e_pc, input logic [3:0] e_cnt, input logic [31:0] e_sw);
    vec_t v;
    v.kind = kind; v.pc = pc; v.fl = fl; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_sel = e_sel; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_sw = e_sw;
    vecs.push_back(v);
  endtask

  // One cycle: drive, settle, (caller checks), advance to next falling edge.
  task automatic step(input int kind, input logic [31:0] pc, input logic fl, input logic ordy);
    drive_kind(kind, pc, fl, ordy);
    @(negedge clk);
  endtask

  task automatic hoist_pair(input logic [31:0] base);
    step(K_LW,   base,        1'b0, 1'b0);
    step(K_ADDU, base + 32'h4, 1'b0, 1'b0);
    step(K_NONE, 32'h0,       1'b0, 1'b1);
    step(K_NONE, 32'h0,       1'b0, 1'b1);
  endtask

  initial begin
    // kind, pc, flush, out_ready | in_ready, out_valid, out_sel, out_pc, count, swaps
    row(K_ADD,  32'h100, 0, 1,  1, 0, 0, 32'h0,   0, 0);  // dependent pair, in order
    row(K_SUB,  32'h104, 0, 1,  1, 1, 0, 32'h100, 1, 0);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h104, 1, 0);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 0);
    row(K_LW,   32'h200, 0, 0,  1, 0, 0, 32'h0,   0, 0);  // load-use hoist
    row(K_ADDU, 32'h204, 0, 0,  1, 1, 0, 32'h200, 1, 0);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 1, 32'h204, 2, 0);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h200, 1, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_LW,   32'h300, 0, 0,  1, 0, 0, 32'h0,   0, 1);  // RAW hazard, no hoist
    row(K_DEP,  32'h304, 0, 0,  1, 1, 0, 32'h300, 1, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h300, 2, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h304, 1, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_NOP,  32'h3F0, 0, 1,  1, 0, 0, 32'h0,   0, 1);  // standalone nop dropped
    row(K_BEQ,  32'h400, 0, 1,  1, 0, 0, 32'h0,   0, 1);
    row(K_NOP,  32'h404, 0, 1,  1, 0, 0, 32'h0,   1, 1);  // branch waits for slot
    row(K_ADDU, 32'h408, 0, 1,  1, 1, 0, 32'h400, 2, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h404, 2, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h408, 1, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_BEQ,  32'h500, 0, 0,  1, 0, 0, 32'h0,   0, 1);  // mem delay slot not overtaken
    row(K_LW,   32'h504, 0, 0,  1, 0, 0, 32'h0,   1, 1);
    row(K_ADDU, 32'h508, 0, 0,  1, 1, 0, 32'h500, 2, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h500, 3, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h504, 2, 1);
    row(K_NONE, 32'h0,   0, 1,  1, 1, 0, 32'h508, 1, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_ADDU, 32'h600, 0, 0,  1, 0, 0, 32'h0,   0, 1);  // fill, full, flush
    row(K_ADDU, 32'h604, 0, 0,  1, 1, 0, 32'h600, 1, 1);
    row(K_ADDU, 32'h608, 0, 0,  1, 1, 0, 32'h600, 2, 1);
    row(K_ADDU, 32'h60C, 0, 0,  1, 1, 0, 32'h600, 3, 1);
    row(K_ADDU, 32'h610, 0, 0,  0, 1, 0, 32'h600, 4, 1);
    row(K_ADDU, 32'h614, 0, 1,  0, 1, 0, 32'h600, 4, 1);
    row(K_ADDU, 32'h618, 0, 0,  1, 1, 0, 32'h604, 3, 1);
    row(K_ADDU, 32'h61C, 1, 1,  0, 1, 0, 32'h604, 4, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_LW,   32'h700, 0, 0,  1, 0, 0, 32'h0,   0, 1);  // flush beats a hoisted issue
    row(K_ADDU, 32'h704, 0, 0,  1, 1, 0, 32'h700, 1, 1);
    row(K_NONE, 32'h0,   1, 1,  1, 1, 1, 32'h704, 2, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);
    row(K_BEQ,  32'h800, 0, 0,  1, 0, 0, 32'h0,   0, 1);  // flush forgets the branch
    row(K_NONE, 32'h0,   1, 0,  1, 0, 0, 32'h0,   1, 1);
    row(K_NOP,  32'h804, 0, 1,  1, 0, 0, 32'h0,   0, 1);
    row(K_NONE, 32'h0,   0, 0,  1, 0, 0, 32'h0,   0, 1);

    resetn = 1'b0;
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("reset_cycle out_valid", 32'(out_valid), 32'd0);
    check("reset_cycle in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_reset count", 32'(count), 32'd0);
    check("post_reset swaps", swaps, 32'd0);
    check("post_reset out_valid", 32'(out_valid), 32'd0);
    check("post_reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_kind(vecs[i].kind, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      #1;
      check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("row%0d swaps", i), swaps, vecs[i].e_sw);
      if (vecs[i].e_ov) begin
        check($sformatf("row%0d out_sel", i), 32'(out_sel), 32'(vecs[i].e_sel));
        check($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
      end
      @(negedge clk);
    end

    // Same hoist stimulus seen by both instances: only the LOOKAHEAD=2 one reorders.
    step(K_LW,   32'h900, 1'b0, 1'b0);
    step(K_ADDU, 32'h904, 1'b0, 1'b0);
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b1);
    #1;
    check("h1 la2 out_sel", 32'(out_sel), 32'd1);
    check("h1 la2 out_instr", out_instr, 32'h016C5021);
    check("h1 la1 out_valid", 32'(out_valid1), 32'd1);
    check("h1 la1 out_sel", 32'(out_sel1), 32'd0);
    check("h1 la1 out_pc", out_pc1, 32'h900);
    @(negedge clk);
    #1;
    check("h1 la2 second pc", out_pc, 32'h900);
    check("h1 la1 second pc", out_pc1, 32'h904);
    check("h1 la1 second sel", 32'(out_sel1), 32'd0);
    @(negedge clk);
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b0);
    #1;
    check("h1 la2 swaps", swaps, 32'd2);
    check("h1 la1 swaps", swaps1, 32'd0);
    check("h1 count", 32'(count), 32'd0);
    @(negedge clk);

    // Strict in-order issue of a dependent pair on the LOOKAHEAD=1 instance.
    step(K_ADD, 32'hA00, 1'b0, 1'b1);
    drive_kind(K_SUB, 32'hA04, 1'b0, 1'b1);
    #1;
    check("io la1 first pc", out_pc1, 32'hA00);
    check("io la1 first sel", 32'(out_sel1), 32'd0);
    @(negedge clk);
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b1);
    #1;
    check("io la1 second pc", out_pc1, 32'hA04);
    check("io la1 second sel", 32'(out_sel1), 32'd0);
    @(negedge clk);
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b0);
    #1;
    check("io la1 swaps", swaps1, 32'd0);
    check("io la1 count", 32'(count1), 32'd0);
    @(negedge clk);

    // Reset with a partly full window and a non-zero swap count.
    for (int h = 0; h < 3; h++) hoist_pair(32'hC00 + 32'(h) * 32'h10);
    step(K_ADDU, 32'hB00, 1'b0, 1'b0);
    step(K_ADDU, 32'hB04, 1'b0, 1'b0);
    step(K_ADDU, 32'hB08, 1'b0, 1'b0);
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b0);
    #1;
    check("pre_reset count", 32'(count), 32'd3);
    check("pre_reset swaps", swaps, 32'd5);
    @(negedge clk);
    resetn = 1'b0;
    drive_kind(K_ADDU, 32'hB0C, 1'b1, 1'b1);
    #1;
    check("mid_reset out_valid", 32'(out_valid), 32'd0);
    check("mid_reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    drive_kind(K_NONE, 32'h0, 1'b0, 1'b1);
    #1;
    check("after_reset count", 32'(count), 32'd0);
    check("after_reset swaps", swaps, 32'd0);
    check("after_reset out_valid", 32'(out_valid), 32'd0);
    check("after_reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
